// File: rtl/ri_context_unit.sv
// JPEG-LS run-interruption context unit: RIType decision, iterative Golomb k, context update.
// Optional RI_STATS_EN adds ri0_count/ri1_count transfer counters.
module ri_context_unit #(
  parameter int unsigned pixel_length = 8,
  parameter int unsigned mode_length  = 2,
  parameter int unsigned RANGE        = 256,
  parameter int unsigned RESET_TH     = 64,
  parameter int unsigned A_width      = 16,
  parameter int unsigned N_width      = 7,
  parameter int unsigned k_width      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [pixel_length-1:0] a,
  input  logic [pixel_length-1:0] b,
  input  logic [mode_length-1:0]  mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    RIType,
  output logic                    a_b_compare,
  output logic [k_width-1:0]      k,
  output logic                    nn_lt,
  input  logic                    upd_valid,
  input  logic [pixel_length:0]   upd_emerr,
  input  logic                    upd_neg
`ifdef RI_STATS_EN
  ,
  output logic [15:0]             ri0_count,
  output logic [15:0]             ri1_count
`endif
);

  localparam int unsigned CmpW  = A_width + 2**k_width;
  localparam int unsigned TempW = A_width + 1;
  localparam int unsigned AInit = ((RANGE + 32) / 64 > 2) ? (RANGE + 32) / 64 : 2;
  localparam logic [A_width-1:0] AMax = '1;
  localparam logic [k_width-1:0] KMax = '1;

  typedef enum logic [1:0] {StIdle, StCalc, StOut, StWaitUpd} state_e;

  state_e state_q, state_d;

  logic                 is_ri_q;
  logic                 ri_type_q;
  logic                 abc_q;
  logic [k_width-1:0]   k_q;
  logic                 nn_lt_q;
  logic [TempW-1:0]     temp_q;

  logic [A_width-1:0]   ctx_a_q  [2];
  logic [N_width-1:0]   ctx_n_q  [2];
  logic [N_width-1:0]   ctx_nn_q [2];

  logic                 is_ri_in;
  logic                 eq_in;
  logic [TempW-1:0]     temp_in;
  logic [CmpW-1:0]      shifted;
  logic                 calc_done;
  logic                 nn_lt_calc;
  logic                 accept;
  logic                 upd_fire;

  logic [CmpW-1:0]      upd_inc;
  logic [CmpW-1:0]      a_sum;
  logic [A_width-1:0]   a_sat;
  logic [N_width-1:0]   nn_sum;
  logic                 halve;
  logic [A_width-1:0]   a_new;
  logic [N_width-1:0]   n_new;
  logic [N_width-1:0]   nn_new;

  assign is_ri_in = (mode == mode_length'(2));
  assign eq_in    = (a == b);
  // RIType 1 adds N/2 to A when forming the k search target.
  assign temp_in  = TempW'(ctx_a_q[eq_in])
                  + (eq_in ? TempW'(ctx_n_q[1] >> 1) : TempW'(0));

  assign shifted    = CmpW'(ctx_n_q[ri_type_q]) << k_q;
  assign calc_done  = (shifted >= CmpW'(temp_q)) || (k_q == KMax);
  assign nn_lt_calc = ({ctx_nn_q[ri_type_q], 1'b0} < {1'b0, ctx_n_q[ri_type_q]});

  assign accept   = (state_q == StIdle) && in_valid;
  assign upd_fire = (state_q == StWaitUpd) && upd_valid;

  assign upd_inc = (CmpW'(upd_emerr) + CmpW'(1) - CmpW'(ri_type_q)) >> 1;
  assign a_sum   = CmpW'(ctx_a_q[ri_type_q]) + upd_inc;
  assign a_sat   = (a_sum > CmpW'(AMax)) ? AMax : a_sum[A_width-1:0];
  assign nn_sum  = ctx_nn_q[ri_type_q] + N_width'(upd_neg);
  assign halve   = (ctx_n_q[ri_type_q] == N_width'(RESET_TH));
  // Halving applies to the already-accumulated A and Nn; N increments afterwards.
  assign a_new   = halve ? (a_sat >> 1) : a_sat;
  assign nn_new  = halve ? (nn_sum >> 1) : nn_sum;
  assign n_new   = (halve ? (ctx_n_q[ri_type_q] >> 1) : ctx_n_q[ri_type_q]) + N_width'(1);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_ri_in ? StCalc : StOut;
      end
      StCalc: begin
        if (calc_done) state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = is_ri_q ? StWaitUpd : StIdle;
      end
      StWaitUpd: begin
        if (upd_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_ri_q      <= 1'b0;
      ri_type_q    <= 1'b0;
      abc_q        <= 1'b0;
      k_q          <= '0;
      nn_lt_q      <= 1'b0;
      temp_q       <= '0;
      ctx_a_q[0]   <= A_width'(AInit);
      ctx_a_q[1]   <= A_width'(AInit);
      ctx_n_q[0]   <= N_width'(1);
      ctx_n_q[1]   <= N_width'(1);
      ctx_nn_q[0]  <= '0;
      ctx_nn_q[1]  <= '0;
    end else begin
      if (accept) begin
        is_ri_q   <= is_ri_in;
        ri_type_q <= is_ri_in & eq_in;
        abc_q     <= is_ri_in & (a > b);
        k_q       <= '0;
        nn_lt_q   <= 1'b0;
        temp_q    <= temp_in;
      end
      if (state_q == StCalc) begin
        if (calc_done) begin
          nn_lt_q <= nn_lt_calc;
        end else begin
          k_q <= k_q + k_width'(1);
        end
      end
      if (upd_fire) begin
        ctx_a_q[ri_type_q]  <= a_new;
        ctx_n_q[ri_type_q]  <= n_new;
        ctx_nn_q[ri_type_q] <= nn_new;
      end
    end
  end

  assign RIType      = ri_type_q;
  assign a_b_compare = abc_q;
  assign k           = k_q;
  assign nn_lt       = nn_lt_q;

`ifdef RI_STATS_EN
  logic stat_xfer;
  assign stat_xfer = out_valid && out_ready && is_ri_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ri0_count <= '0;
      ri1_count <= '0;
    end else if (stat_xfer) begin
      if (ri_type_q) begin
        if (ri1_count != 16'hFFFF) ri1_count <= ri1_count + 16'd1;
      end else begin
        if (ri0_count != 16'hFFFF) ri0_count <= ri0_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ri_context_unit.sv
// Randomized self-checking bench for ri_context_unit against a behavioural context model.
module tb_ri_context_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        RIType;
  logic        a_b_compare;
  logic [3:0]  k;
  logic        nn_lt;
  logic        upd_valid;
  logic [8:0]  upd_emerr;
  logic        upd_neg;
`ifdef RI_STATS_EN
  logic [15:0] ri0_count;
  logic [15:0] ri1_count;
`endif

  always #5 clk = ~clk;

  ri_context_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .RIType      (RIType),
    .a_b_compare (a_b_compare),
    .k           (k),
    .nn_lt       (nn_lt),
    .upd_valid   (upd_valid),
    .upd_emerr   (upd_emerr),
    .upd_neg     (upd_neg)
`ifdef RI_STATS_EN
    ,
    .ri0_count   (ri0_count),
    .ri1_count   (ri1_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference contexts and transfer counters
  int ma [2];
  int mn [2];
  int mnn [2];
  int m_ri0, m_ri1;
  bit last_ri;
  int last_rt;

  logic [3:0] obs_k;
  logic       obs_nnlt;
  logic       obs_abc;
  logic       obs_rt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ma[i]  = 4;
      mn[i]  = 1;
      mnn[i] = 0;
    end
    m_ri0 = 0;
    m_ri1 = 0;
  endtask

  // Smallest k with N*2^k >= temp, capped at 15.
  function automatic int model_k(input int temp, input int n);
    int kk = 0;
    while (kk < 15 && (longint'(n) << kk) < longint'(temp)) kk++;
    return kk;
  endfunction

  task automatic model_update(input int rt, input int em, input int ng);
    int aa;
    aa = ma[rt] + ((em + 1 - rt) / 2);
    if (aa > 65535) aa = 65535;
    mnn[rt] = mnn[rt] + ng;
    if (mn[rt] == 64) begin
      aa      = aa / 2;
      mn[rt]  = mn[rt] / 2;
      mnn[rt] = mnn[rt] / 2;
    end
    mn[rt] = mn[rt] + 1;
    ma[rt] = aa;
  endtask

  task automatic do_req(input int av, input int bv, input int md, input int hold, input bit early);
    bit ri;
    int rt, eabc, ek, enl, elat, temp, cnt;
    ri   = (md == 2);
    rt   = (ri && av == bv) ? 1 : 0;
    eabc = (ri && av > bv) ? 1 : 0;
    ek   = 0;
    enl  = 0;
    elat = 0;
    if (ri) begin
      temp = ma[rt] + (rt == 1 ? mn[rt] / 2 : 0);
      ek   = model_k(temp, mn[rt]);
      enl  = (2 * mnn[rt] < mn[rt]) ? 1 : 0;
      elat = ek + 1;  // edges after the accept edge until out_valid is seen
    end
    check_eq("in_ready_idle", in_ready, 1);
    a         = av[7:0];
    b         = bv[7:0];
    mode      = md[1:0];
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("latency", cnt, elat);
    check_eq("ritype", RIType, rt);
    check_eq("a_b_compare", a_b_compare, eabc);
    check_eq("k", k, ek);
    check_eq("nn_lt", nn_lt, enl);
    obs_k    = k;
    obs_nnlt = nn_lt;
    obs_abc  = a_b_compare;
    obs_rt   = RIType;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_in_ready", in_ready, 0);
        check_eq("hold_k", k, ek);
        check_eq("hold_ritype", RIType, rt);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("out_valid_drop", out_valid, 0);
    if (ri) begin
      if (rt == 1) m_ri1++;
      else m_ri0++;
    end else begin
      check_eq("in_ready_after_nonri", in_ready, 1);
    end
    last_ri = ri;
    last_rt = rt;
  endtask

  task automatic do_upd(input int em, input int ng, input int gap);
    for (int i = 0; i < gap; i++) begin
      check_eq("in_ready_wait", in_ready, 0);
      @(posedge clk);
      #1;
    end
    upd_emerr = em[8:0];
    upd_neg   = ng[0];
    upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    model_update(last_rt, em, ng);
    check_eq("in_ready_after_upd", in_ready, 1);
  endtask

  // Update strobe while idle must be ignored.
  task automatic stray_upd();
    upd_emerr = 9'($urandom_range(0, 511));
    upd_neg   = 1'($urandom_range(0, 1));
    upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int av, bv;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = '0;
    out_ready = 1'b0;
    upd_valid = 1'b0;
    upd_emerr = '0;
    upd_neg   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_ritype", RIType, 0);
    check_eq("rst_abc", a_b_compare, 0);
    check_eq("rst_k", k, 0);
    check_eq("rst_nn_lt", nn_lt, 0);
    rst_n = 1'b1;

    // Equal neighbours pick RIType 1 on a fresh context
    do_req(10, 10, 2, 0, 1'b0);
    check_eq("tp1_k", obs_k, 2);
    check_eq("tp1_nnlt", obs_nnlt, 1);
    do_upd(0, 0, 1);

    // RIType 0, update, then a dependent request
    do_reset();
    do_req(20, 5, 2, 0, 1'b0);
    check_eq("tp2_abc", obs_abc, 1);
    check_eq("tp2_k", obs_k, 2);
    do_upd(9, 1, 0);
    do_req(3, 7, 2, 0, 1'b1);
    check_eq("tp2b_k", obs_k, 3);
    check_eq("tp2b_nnlt", obs_nnlt, 0);
    do_upd(4, 0, 0);

    // Non-RI mode bypasses contexts and needs no update
    do_req(7, 7, 1, 0, 1'b0);
    check_eq("tp3_ritype", obs_rt, 0);
    stray_upd();

    // Drive ctx1 to the halving threshold and one past it
    do_reset();
    for (int i = 0; i < 64; i++) begin
      av = $urandom_range(0, 255);
      do_req(av, av, 2, 0, 1'($urandom_range(0, 1)));
      do_upd(1, $urandom_range(0, 1), 0);
    end
    do_req(40, 40, 2, 0, 1'b0);
    check_eq("tp4_k_ctx1", obs_k, 0);
    do_upd(2, 0, 0);
    do_req(9, 3, 2, 0, 1'b0);
    check_eq("tp4_k_ctx0", obs_k, 2);
    do_upd(3, 1, 0);

    // Backpressure in OUT, then reset while waiting for the update
    do_req(100, 50, 2, 5, 1'b0);
    upd_valid = 1'b1;
    upd_emerr = 9'd400;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    model_reset();
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_k", k, 0);
    check_eq("mid_rst_ritype", RIType, 0);

    do_req(5, 5, 2, 0, 1'b0);
    check_eq("tp5_k", obs_k, 2);
    check_eq("tp5_nnlt", obs_nnlt, 1);
    do_upd(1, 0, 0);
    do_req(6, 6, 2, 0, 1'b0);
    do_upd(7, 1, 0);
    do_req(7, 7, 2, 1, 1'b0);
    do_upd(2, 0, 0);
    do_req(9, 2, 2, 0, 1'b1);
    do_upd(11, 1, 0);
    do_req(1, 8, 2, 2, 1'b0);
    do_upd(5, 0, 0);
    do_req(4, 4, 0, 0, 1'b0);
`ifdef RI_STATS_EN
    check_eq("tp6_ri1_count", ri1_count, 3);
    check_eq("tp6_ri0_count", ri0_count, 2);
`endif

    // Randomized traffic
    for (int i = 0; i < 100; i++) begin
      av = $urandom_range(0, 255);
      bv = ($urandom_range(0, 2) == 0) ? av : int'($urandom_range(0, 255));
      do_req(av, bv, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (last_ri) begin
        do_upd($urandom_range(0, 511), $urandom_range(0, 1), $urandom_range(0, 2));
      end else if ($urandom_range(0, 1) == 1) begin
        stray_upd();
      end
    end
`ifdef RI_STATS_EN
    check_eq("ri1_count", ri1_count, m_ri1);
    check_eq("ri0_count", ri0_count, m_ri0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
